// File: rtl/types_pkg.sv
// Shared types for the stream encryptor: FSM states and keystream request tracking.
// Consumed by stream_encryptor and keystream_buffer (STREAM_ENCRYPTOR_PREFETCH_EN build).
package types_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_KEY,
        OUTPUT
    } stream_encryptor_state_t;

    // Whether a keystream request is outstanding at the generator.
    typedef enum logic {
        KS_IDLE,
        KS_PENDING
    } keystream_gen_state_t;

endpackage

// File: rtl/keystream_buffer.sv
// One-entry holding register for a prefetched keystream byte.
// Instantiated by stream_encryptor only when STREAM_ENCRYPTOR_PREFETCH_EN is defined.
module keystream_buffer
    import types_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              fill,
    input  logic [BYTE_W-1:0] fill_data,
    input  logic              consume,
    output logic [BYTE_W-1:0] data,
    output logic              full
);

    logic [BYTE_W-1:0] data_q, data_d;
    logic              full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (consume) begin
            full_d = 1'b0;
        end
        if (fill) begin
            data_d = fill_data;
            full_d = 1'b1;
        end
        if (clear) begin
            data_d = '0;
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/stream_encryptor.sv
// Encrypts one plaintext byte at a time by XOR with a keystream byte fetched on request.
// Define STREAM_ENCRYPTOR_PREFETCH_EN to keep one keystream byte prefetched ahead of need.
module stream_encryptor
    import types_pkg::*;
#(
    parameter int RESPONSE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              request_hash_byte_pulse_out,
    input  logic [BYTE_W-1:0] hash_byte_in,
    input  logic              hash_byte_pulse_in,
    output logic              reset_hash_out,
    output logic              timeout_error
);

    localparam int              CNT_W   = $clog2(RESPONSE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESPONSE_TIMEOUT);

    stream_encryptor_state_t state_q, state_d;
    logic [BYTE_W-1:0]       plain_q, plain_d;
    logic [BYTE_W-1:0]       data_out_q, data_out_d;
    logic                    data_out_valid_q, data_out_valid_d;
    logic                    request_q, request_d;
    logic                    timeout_error_q, timeout_error_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

    logic [CNT_W-1:0]        wait_cnt_inc;
    logic                    timeout_hit;
    logic                    key_avail;
    logic [BYTE_W-1:0]       key_byte;

    assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    assign timeout_hit  = (wait_cnt_inc == CNT_MAX);

`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
    keystream_gen_state_t ks_state_q, ks_state_d;
    logic                 key_arrive;
    logic                 take_key;
    logic                 buf_fill;
    logic                 buf_consume;
    logic [BYTE_W-1:0]    buf_data;
    logic                 buf_full;

    // A byte already in the buffer takes precedence over one arriving this cycle.
    assign key_arrive = hash_byte_pulse_in && (ks_state_q == KS_PENDING);
    assign key_avail  = buf_full || key_arrive;
    assign key_byte   = buf_full ? buf_data : hash_byte_in;

    keystream_buffer u_keystream_buffer (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .fill      (buf_fill),
        .fill_data (hash_byte_in),
        .consume   (buf_consume),
        .data      (buf_data),
        .full      (buf_full)
    );
`else
    assign key_avail = hash_byte_pulse_in;
    assign key_byte  = hash_byte_in;
`endif

    always_comb begin
        state_d          = state_q;
        plain_d          = plain_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        request_d        = 1'b0;
        timeout_error_d  = timeout_error_q;
        wait_cnt_d       = wait_cnt_q;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
        take_key         = 1'b0;
        ks_state_d       = ks_state_q;
        buf_fill         = 1'b0;
        buf_consume      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    plain_d = data_in;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
                    if (key_avail) begin
                        data_out_d       = data_in ^ key_byte;
                        data_out_valid_d = 1'b1;
                        take_key         = 1'b1;
                        state_d          = OUTPUT;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = WAIT_KEY;
                    end
`else
                    request_d = 1'b1;
                    state_d   = REQUEST;
`endif
                end
            end
            REQUEST: begin
                wait_cnt_d = '0;
                state_d    = WAIT_KEY;
            end
            WAIT_KEY: begin
                wait_cnt_d = wait_cnt_inc;
                if (timeout_hit) begin
                    timeout_error_d = 1'b1;
                end
                if (key_avail) begin
                    data_out_d       = plain_q ^ key_byte;
                    data_out_valid_d = 1'b1;
                    state_d          = OUTPUT;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
                    take_key         = 1'b1;
`endif
                end else if (timeout_hit) begin
                    request_d = 1'b1;
                    state_d   = REQUEST;
                end
            end
            OUTPUT: begin
                if (data_out_ready) begin
                    data_out_valid_d = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
        // Keep exactly one request outstanding whenever the buffer is empty.
        if (key_arrive) begin
            ks_state_d = KS_IDLE;
        end
        if ((ks_state_q == KS_IDLE) && !buf_full) begin
            request_d = 1'b1;
        end
        if (request_d) begin
            ks_state_d = KS_PENDING;
        end
        buf_fill    = key_arrive && !take_key;
        buf_consume = take_key && buf_full;
`endif

        if (clear) begin
            state_d          = IDLE;
            plain_d          = '0;
            data_out_d       = '0;
            data_out_valid_d = 1'b0;
            request_d        = 1'b0;
            timeout_error_d  = 1'b0;
            wait_cnt_d       = '0;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
            ks_state_d       = KS_IDLE;
            buf_fill         = 1'b0;
            buf_consume      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q          <= IDLE;
            plain_q          <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            request_q        <= 1'b0;
            timeout_error_q  <= 1'b0;
            wait_cnt_q       <= '0;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
            ks_state_q       <= KS_IDLE;
`endif
        end else begin
            state_q          <= state_d;
            plain_q          <= plain_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            request_q        <= request_d;
            timeout_error_q  <= timeout_error_d;
            wait_cnt_q       <= wait_cnt_d;
`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
            ks_state_q       <= ks_state_d;
`endif
        end
    end

    assign data_in_ready               = (state_q == IDLE);
    assign data_out                    = data_out_q;
    assign data_out_valid              = data_out_valid_q;
    assign request_hash_byte_pulse_out = request_q;
    assign reset_hash_out              = clear;
    assign timeout_error               = timeout_error_q;

endmodule

// File: tb/tb_stream_encryptor.sv
// Directed bench for stream_encryptor with RESPONSE_TIMEOUT=8; the keystream source is played by hand.
// Runs the prefetch sequence when STREAM_ENCRYPTOR_PREFETCH_EN is defined.
module tb_stream_encryptor;

    localparam logic [7:0] KS0 = 8'h5A;

    logic       clk = 1'b0;
    logic       nrst;
    logic       clear;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       request_hash_byte_pulse_out;
    logic [7:0] hash_byte_in;
    logic       hash_byte_pulse_in;
    logic       reset_hash_out;
    logic       timeout_error;

    int checks   = 0;
    int failures = 0;
    int req_seen = 0;

    stream_encryptor #(.RESPONSE_TIMEOUT(8)) dut (
        .clk                         (clk),
        .nrst                        (nrst),
        .clear                       (clear),
        .data_in                     (data_in),
        .data_in_valid               (data_in_valid),
        .data_in_ready               (data_in_ready),
        .data_out                    (data_out),
        .data_out_valid              (data_out_valid),
        .data_out_ready              (data_out_ready),
        .request_hash_byte_pulse_out (request_hash_byte_pulse_out),
        .hash_byte_in                (hash_byte_in),
        .hash_byte_pulse_in          (hash_byte_pulse_in),
        .reset_hash_out              (reset_hash_out),
        .timeout_error               (timeout_error)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and tally any request pulse seen there.
    task automatic cycle();
        @(negedge clk);
        if (request_hash_byte_pulse_out === 1'b1) begin
            req_seen++;
        end
    endtask

    initial begin
        nrst               = 1'b0;
        clear              = 1'b0;
        data_in            = 8'h00;
        data_in_valid      = 1'b0;
        data_out_ready     = 1'b0;
        hash_byte_in       = 8'h00;
        hash_byte_pulse_in = 1'b0;
        repeat (3) @(negedge clk);

        check1("rst_in_ready", data_in_ready, 1'b1);
        check1("rst_out_valid", data_out_valid, 1'b0);
        check8("rst_data_out", data_out, 8'h00);
        check1("rst_request", request_hash_byte_pulse_out, 1'b0);
        check1("rst_timeout", timeout_error, 1'b0);
        nrst = 1'b1;

`ifdef STREAM_ENCRYPTOR_PREFETCH_EN
        cycle();
        check1("pf_req_on_reset_exit", request_hash_byte_pulse_out, 1'b1);
        cycle();
        check1("pf_req_single", request_hash_byte_pulse_out, 1'b0);
        hash_byte_in = 8'h33; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("pf_no_req_when_full", request_hash_byte_pulse_out, 1'b0);
        data_in = 8'h33; data_in_valid = 1'b1; data_out_ready = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        check1("pf_fast_valid", data_out_valid, 1'b1);
        check8("pf_fast_data", data_out, 8'h00);
        cycle();
        check1("pf_refill_req", request_hash_byte_pulse_out, 1'b1);
        check1("pf_back_idle", data_in_ready, 1'b1);
        data_in = 8'h0F; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        check1("pf_wait_no_valid", data_out_valid, 1'b0);
        hash_byte_in = 8'hF0; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("pf_empty_valid", data_out_valid, 1'b1);
        check8("pf_empty_data", data_out, 8'hFF);
        check1("pf_no_timeout", timeout_error, 1'b0);
`else
        cycle();

        // 0x41 against keystream byte 0, answered on the third WAIT_KEY cycle.
        req_seen = 0;
        data_in = 8'h41; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        check1("req_pulse", request_hash_byte_pulse_out, 1'b1);
        check1("in_ready_busy", data_in_ready, 1'b0);
        repeat (3) cycle();
        check1("valid_before_key", data_out_valid, 1'b0);
        hash_byte_in = KS0; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("valid_5_after_capture", data_out_valid, 1'b1);
        check8("cipher_41", data_out, 8'h1B);
        check8("one_request", 8'(req_seen), 8'd1);

        for (int i = 0; i < 10; i++) begin
            cycle();
            check8("hold_data", data_out, 8'h1B);
            check1("hold_valid", data_out_valid, 1'b1);
            check1("hold_in_ready", data_in_ready, 1'b0);
        end
        check8("hold_no_extra_req", 8'(req_seen), 8'd1);
        data_out_ready = 1'b1;
        cycle();
        check1("drain_valid", data_out_valid, 1'b0);
        check1("drain_in_ready", data_in_ready, 1'b1);

        // No answer: eight WAIT_KEY cycles then a reissued request.
        req_seen = 0;
        data_in = 8'hC4; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        repeat (8) cycle();
        check1("timeout_not_yet", timeout_error, 1'b0);
        cycle();
        check1("timeout_set", timeout_error, 1'b1);
        check1("reissue_pulse", request_hash_byte_pulse_out, 1'b1);
        check8("two_requests", 8'(req_seen), 8'd2);
        cycle();
        hash_byte_in = 8'hFF; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("retry_valid", data_out_valid, 1'b1);
        check8("retry_data", data_out, 8'h3B);
        cycle();
        check1("timeout_sticky", timeout_error, 1'b1);

        hash_byte_in = 8'h77; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("stray_no_valid", data_out_valid, 1'b0);
        check1("stray_in_ready", data_in_ready, 1'b1);
        check8("stray_data_kept", data_out, 8'h3B);
        check8("stray_no_req", 8'(req_seen), 8'd2);
        cycle();
        check1("stray_still_idle", data_in_ready, 1'b1);

        // Clear while waiting for a key, then the keystream restarts at byte 0.
        data_in = 8'h99; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        repeat (2) cycle();
        clear = 1'b1;
        #1;
        check1("reset_hash_high", reset_hash_out, 1'b1);
        cycle();
        clear = 1'b0;
        #1;
        check1("reset_hash_low", reset_hash_out, 1'b0);
        check1("clear_timeout", timeout_error, 1'b0);
        check1("clear_idle", data_in_ready, 1'b1);
        check1("clear_valid", data_out_valid, 1'b0);
        check8("clear_data", data_out, 8'h00);

        req_seen = 0;
        data_in = 8'h00; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        check1("post_clear_req", request_hash_byte_pulse_out, 1'b1);
        cycle();
        hash_byte_in = KS0; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("min_latency_valid", data_out_valid, 1'b1);
        check8("ks_byte0", data_out, KS0);
        check1("post_clear_timeout", timeout_error, 1'b0);
        cycle();

        // Key arrives on the very cycle the wait budget runs out.
        req_seen = 0;
        data_in = 8'h10; data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        repeat (8) cycle();
        check1("tie_timeout_not_yet", timeout_error, 1'b0);
        hash_byte_in = 8'h01; hash_byte_pulse_in = 1'b1;
        cycle();
        hash_byte_pulse_in = 1'b0;
        check1("tie_key_wins", data_out_valid, 1'b1);
        check8("tie_data", data_out, 8'h11);
        check1("tie_timeout_set", timeout_error, 1'b1);
        check8("tie_no_reissue", 8'(req_seen), 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_encryptor.md
STREAM_ENCRYPTOR -- requirements
Module: stream_encryptor

Interface
REQ-001 SHALL have parameter RESPONSE_TIMEOUT, default 1024, meaning the maximum number of cycles in WAIT_KEY before a timeout is flagged.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous restart of the encryptor and the keystream source.
REQ-005 data_in  input  8  plaintext byte.
REQ-006 data_in_valid  input  1  data_in is valid.
REQ-007 data_in_ready  output  1  encryptor accepts data_in this cycle.
REQ-008 data_out  output  8  ciphertext byte, equal to plaintext XOR keystream byte.
REQ-009 data_out_valid  output  1  data_out is valid.
REQ-010 data_out_ready  input  1  sink accepts data_out.
REQ-011 request_hash_byte_pulse_out  output  1  one-cycle request for the next keystream byte.
REQ-012 hash_byte_in  input  8  keystream byte; sampled only when hash_byte_pulse_in=1.
REQ-013 hash_byte_pulse_in  input  1  one-cycle strobe marking hash_byte_in as valid.
REQ-014 reset_hash_out  output  1  keystream restart; combinationally equal to clear.
REQ-015 timeout_error  output  1  sticky flag raised on keystream response timeout.

Function
REQ-016 FSM states: IDLE, REQUEST, WAIT_KEY, OUTPUT.
REQ-017 IDLE: data_in_ready=1; data_in_valid=1 captures data_in into plain_reg and moves to REQUEST.
REQ-018 REQUEST: request_hash_byte_pulse_out=1 for exactly one cycle; next state is WAIT_KEY.
REQ-019 WAIT_KEY: hash_byte_pulse_in=1 registers data_out=plain_reg^hash_byte_in and moves to OUTPUT.
REQ-020 OUTPUT: data_out_valid=1 and data_out held stable until data_out_ready=1, then IDLE.
REQ-021 data_in_ready SHALL be 0 in every state except IDLE, so at most one byte is in flight.
REQ-022 Minimum latency SHALL be 3 cycles: capture, request, key; data_out_valid rises on the cycle after hash_byte_pulse_in.
REQ-023 hash_byte_pulse_in outside WAIT_KEY SHALL be ignored, with no state change (non-prefetch build).
REQ-024 Wait counter SHALL clear on entry to WAIT_KEY and increment each WAIT_KEY cycle, saturating.
REQ-025 When the wait counter reaches RESPONSE_TIMEOUT, timeout_error SHALL be set and the FSM SHALL return to REQUEST to reissue the request.
REQ-026 timeout_error SHALL stay set until nrst or clear.
REQ-027 If hash_byte_pulse_in coincides with timeout: the key byte wins; timeout_error is still set.
REQ-028 clear=1 SHALL override all other inputs in that cycle: the FSM, registers and outputs take their reset values, and any in-flight byte is dropped.

Reset
REQ-029 On nrst low the FSM SHALL be IDLE and all registers/outputs 0, except data_in_ready=1 (combinational from IDLE).
REQ-030 The first request after reset or clear SHALL correspond to keystream byte 0.

Configuration
REQ-031 Macro STREAM_ENCRYPTOR_PREFETCH_EN compiled in: a one-entry keystream buffer.
  - A request is issued on reset exit and again after each buffered byte is consumed.
  - A captured plaintext byte with the buffer full goes IDLE->OUTPUT in 1 cycle, skipping REQUEST/WAIT_KEY.
  - With the buffer empty, the FSM waits in WAIT_KEY as normal.
  - hash_byte_pulse_in with a pending request fills the buffer in any state.
REQ-032 Macro absent: no buffer; behaviour exactly per REQ-016..REQ-027.

Structure
REQ-033 The stream_encryptor_state_t enum SHALL live in types_pkg, alongside the keystream generator state type.
REQ-034 The prefetch buffer SHALL be sub-module keystream_buffer: 8-bit data, full flag, fill/consume ports, instantiated only under the macro.
REQ-035 The wait-counter width SHALL be $clog2(RESPONSE_TIMEOUT+1).

Verification
REQ-036 Send 0x41 with keystream model returning 0x5A after 2 cycles -> exactly one request pulse; data_out=0x1B; data_out_valid 5 cycles after capture.
REQ-037 Hold data_out_ready=0 for 10 cycles -> data_out stays 0x1B, data_out_valid stays 1, data_in_ready stays 0, no extra requests.
REQ-038 RESPONSE_TIMEOUT=8, no key response -> timeout_error=1 after 8 WAIT_KEY cycles; second request pulse; key 0xFF then yields data_out=plain^0xFF.
REQ-039 Assert clear mid-WAIT_KEY, then send 0x00 -> reset_hash_out pulses; data_out equals keystream byte 0; timeout_error=0.
REQ-040 Stray hash_byte_pulse_in in IDLE -> no output, no state change (non-prefetch build).
REQ-041 Prefetch build, buffer full with 0x33, send 0x33 -> data_out=0x00 one cycle after capture; new request issued.
